csr_access_unit: RTL and testbench

Sequencer sitting directly upstream of the CSR register file. Accepts one decoded Zicsr instruction at a time from the execute stage, reads the addressed CSR, computes the read-modify-write result, drives the register file's single write port, and returns the old CSR value to writeback. Illegal accesses are flagged instead of written.

---
 rtl/csr_pkg.sv | 24 ++
 rtl/csr_access_unit_if.sv | 49 ++++
 rtl/csr_alu.sv | 44 ++++
 rtl/csr_access_unit.sv | 122 ++++++++++++
 tb/tb_csr_access_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access sequencer:
// Zicsr funct3 codes, FSM encoding and the default data width.
package csr_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Immediate forms carry a 5-bit zimm in the rs1 field.
    function automatic logic is_imm_form(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response handshake between execute/writeback
// and the CSR access sequencer.
interface csr_access_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_csr;
    logic [4:0]      req_src_idx;
    logic [XLEN-1:0] req_rs1_data;
    logic [4:0]      req_rd;

    logic            resp_valid;
    logic            resp_ready;
    logic [4:0]      resp_rd;
    logic [XLEN-1:0] resp_data;
    logic            resp_illegal;

    modport master (
        output req_valid,
        output req_funct3,
        output req_csr,
        output req_src_idx,
        output req_rs1_data,
        output req_rd,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rd,
        input  resp_data,
        input  resp_illegal
    );

    modport slave (
        input  req_valid,
        input  req_funct3,
        input  req_csr,
        input  req_src_idx,
        input  req_rs1_data,
        input  req_rd,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rd,
        output resp_data,
        output resp_illegal
    );
endinterface

// File: rtl/csr_alu.sv
// Read-modify-write datapath for Zicsr instructions:
// new value, write enable and bad-funct3 detection.
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    input  logic [4:0]      src_idx,
    output logic [XLEN-1:0] new_val,
    output logic            wr_en,
    output logic            illegal_op
);

    logic src_nonzero;

    assign src_nonzero = (src_idx != 5'd0);

    always_comb begin
        new_val    = '0;
        wr_en      = 1'b0;
        illegal_op = 1'b0;
        unique case (funct3)
            CSR_RW, CSR_RWI: begin
                new_val = src;
                wr_en   = 1'b1;
            end
            CSR_RS, CSR_RSI: begin
                new_val = old_val | src;
                wr_en   = src_nonzero;
            end
            CSR_RC, CSR_RCI: begin
                new_val = old_val & ~src;
                wr_en   = src_nonzero;
            end
            default: begin
                illegal_op = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Four-state sequencer that reads a CSR, writes back the
// modified value through one write port and returns the old value.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int NUM_CSRS = 8,
    parameter int XLEN     = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    csr_access_unit_if.slave bus,
    output logic            csr_we,
    output logic [31:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata
);

    localparam logic [11:0] CSR_LIMIT = 12'(NUM_CSRS);

    logic [1:0]      state;
    logic [2:0]      funct3_q;
    logic [11:0]     csr_q;
    logic [4:0]      idx_q;
    logic [XLEN-1:0] rs1_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] new_q;
    logic            we_q;
    logic            ill_q;

    logic [XLEN-1:0] src;
    logic [XLEN-1:0] alu_new;
    logic            alu_we;
    logic            alu_ill;
    logic            csr_oob;
    logic            ill;

    logic in_idle;
    logic in_write;
    logic in_resp;

    assign in_idle  = (state == ST_IDLE);
    assign in_write = (state == ST_WRITE);
    assign in_resp  = (state == ST_RESP);

    assign src = is_imm_form(funct3_q)
               ? {{(XLEN-5){1'b0}}, idx_q}
               : rs1_q;

    csr_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .funct3     (funct3_q),
        .old_val    (csr_rdata),
        .src        (src),
        .src_idx    (idx_q),
        .new_val    (alu_new),
        .wr_en      (alu_we),
        .illegal_op (alu_ill)
    );

    assign csr_oob = (csr_q >= CSR_LIMIT);
    assign ill     = alu_ill | csr_oob;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            funct3_q <= '0;
            csr_q    <= '0;
            idx_q    <= '0;
            rs1_q    <= '0;
            rd_q     <= '0;
            old_q    <= '0;
            new_q    <= '0;
            we_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        funct3_q <= bus.req_funct3;
                        csr_q    <= bus.req_csr;
                        idx_q    <= bus.req_src_idx;
                        rs1_q    <= bus.req_rs1_data;
                        rd_q     <= bus.req_rd;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    old_q <= csr_rdata;
                    new_q <= alu_new;
                    we_q  <= alu_we & ~ill;
                    ill_q <= ill;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so a reset clears them at once.
    assign csr_we    = in_write & we_q;
    assign csr_addr  = in_idle ? 32'd0 : {20'd0, csr_q};
    assign csr_wdata = in_write ? new_q : '0;

    assign bus.req_ready    = in_idle;
    assign bus.resp_valid   = in_resp;
    assign bus.resp_rd      = in_resp ? rd_q : 5'd0;
    assign bus.resp_data    = (in_resp && !ill_q) ? old_q : '0;
    assign bus.resp_illegal = in_resp & ill_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with an 8-entry
// register-file model on the CSR write/read ports.
module tb_csr_access_unit;
    import csr_pkg::*;

    logic        clk;
    logic        reset;
    logic        csr_we;
    logic [31:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] rf [8];

    int tests;
    int fails;

    int          o_we_cnt;
    int          o_lat;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [31:0] o_data;
    logic [4:0]  o_rd;
    logic        o_ill;

    csr_access_unit_if #(.XLEN(32)) bus ();

    csr_access_unit #(
        .NUM_CSRS (8),
        .XLEN     (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (csr_we && csr_addr < 32'd8) begin
            rf[csr_addr[2:0]] <= csr_wdata;
        end
    end

    assign csr_rdata = (csr_addr < 32'd8) ? rf[csr_addr[2:0]] : 32'd0;

    task automatic issue(input logic [2:0] f3, input logic [11:0] csr,
                         input logic [4:0] idx, input logic [31:0] rs1,
                         input logic [4:0] rd);
        int n;
        o_we_cnt = 0;
        o_lat    = 0;
        o_addr   = '0;
        o_wdata  = '0;
        o_data   = '0;
        o_rd     = '0;
        o_ill    = 1'b0;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_funct3   = f3;
        bus.req_csr      = csr;
        bus.req_src_idx  = idx;
        bus.req_rs1_data = rs1;
        bus.req_rd       = rd;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (csr_we) begin
                o_we_cnt++;
                o_addr  = csr_addr;
                o_wdata = csr_wdata;
            end
            if (bus.resp_valid) begin
                o_lat  = c;
                o_data = bus.resp_data;
                o_rd   = bus.resp_rd;
                o_ill  = bus.resp_illegal;
                break;
            end
        end
        if (o_lat != 0 && bus.resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        tests++; if (bus.resp_illegal !== 1'b0) begin fails++; $display("FAIL reset_resp_illegal got %b want 0", bus.resp_illegal); end
        tests++; if (csr_we !== 1'b0) begin fails++; $display("FAIL reset_csr_we got %b want 0", csr_we); end
        tests++; if (bus.resp_rd !== 5'd0) begin fails++; $display("FAIL reset_resp_rd got %0d want 0", bus.resp_rd); end
        tests++; if (bus.resp_data !== 32'd0) begin fails++; $display("FAIL reset_resp_data got %h want 0", bus.resp_data); end
        tests++; if (csr_addr !== 32'd0) begin fails++; $display("FAIL reset_csr_addr got %h want 0", csr_addr); end
        tests++; if (csr_wdata !== 32'd0) begin fails++; $display("FAIL reset_csr_wdata got %h want 0", csr_wdata); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_rw();
        issue(CSR_RW, 12'd3, 5'd1, 32'hDEADBEEF, 5'd5);
        tests++; if (o_we_cnt !== 1) begin fails++; $display("FAIL rw_we_pulses got %0d want 1", o_we_cnt); end
        tests++; if (o_addr !== 32'd3) begin fails++; $display("FAIL rw_addr got %h want 3", o_addr); end
        tests++; if (o_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rw_wdata got %h want deadbeef", o_wdata); end
        tests++; if (o_data !== 32'd0) begin fails++; $display("FAIL rw_resp_data got %h want 0", o_data); end
        tests++; if (o_rd !== 5'd5) begin fails++; $display("FAIL rw_resp_rd got %0d want 5", o_rd); end
        tests++; if (o_lat !== 3) begin fails++; $display("FAIL rw_latency got %0d want 3", o_lat); end
        tests++; if (o_ill !== 1'b0) begin fails++; $display("FAIL rw_illegal got %b want 0", o_ill); end
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rw_idle_ready got %b want 1", bus.req_ready); end
        tests++; if (csr_addr !== 32'd0) begin fails++; $display("FAIL rw_idle_addr got %h want 0", csr_addr); end
    endtask

    task automatic test_set_clear();
        issue(CSR_RS, 12'd3, 5'd2, 32'h000000F0, 5'd6);
        tests++; if (o_wdata !== 32'hDEADBEFF) begin fails++; $display("FAIL rs_wdata got %h want deadbeff", o_wdata); end
        tests++; if (o_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rs_resp_data got %h want deadbeef", o_data); end
        tests++; if (o_we_cnt !== 1) begin fails++; $display("FAIL rs_we_pulses got %0d want 1", o_we_cnt); end
        issue(CSR_RCI, 12'd3, 5'h0F, 32'hFFFFFFFF, 5'd7);
        tests++; if (o_wdata !== 32'hDEADBEF0) begin fails++; $display("FAIL rci_wdata got %h want deadbef0", o_wdata); end
        tests++; if (o_data !== 32'hDEADBEFF) begin fails++; $display("FAIL rci_resp_data got %h want deadbeff", o_data); end
        issue(CSR_RSI, 12'd3, 5'd0, 32'hFFFFFFFF, 5'd8);
        tests++; if (o_we_cnt !== 0) begin fails++; $display("FAIL rsi0_we_pulses got %0d want 0", o_we_cnt); end
        tests++; if (o_data !== 32'hDEADBEF0) begin fails++; $display("FAIL rsi0_resp_data got %h want deadbef0", o_data); end
        issue(CSR_RC, 12'd3, 5'd0, 32'hFFFFFFFF, 5'd9);
        tests++; if (o_we_cnt !== 0) begin fails++; $display("FAIL rc_x0_we_pulses got %0d want 0", o_we_cnt); end
        tests++; if (o_data !== 32'hDEADBEF0) begin fails++; $display("FAIL rc_x0_resp_data got %h want deadbef0", o_data); end
        issue(CSR_RWI, 12'd7, 5'h15, 32'hFFFFFFFF, 5'd10);
        tests++; if (o_wdata !== 32'h00000015) begin fails++; $display("FAIL rwi_top_wdata got %h want 15", o_wdata); end
        tests++; if (o_ill !== 1'b0) begin fails++; $display("FAIL rwi_top_illegal got %b want 0", o_ill); end
        issue(CSR_RCI, 12'd7, 5'h04, 32'd0, 5'd10);
        tests++; if (o_wdata !== 32'h00000011) begin fails++; $display("FAIL rci_top_wdata got %h want 11", o_wdata); end
        tests++; if (o_data !== 32'h00000015) begin fails++; $display("FAIL rci_top_resp_data got %h want 15", o_data); end
    endtask

    task automatic test_illegal();
        issue(CSR_RW, 12'd9, 5'd1, 32'h12345678, 5'd4);
        tests++; if (o_we_cnt !== 0) begin fails++; $display("FAIL ill_csr9_we got %0d want 0", o_we_cnt); end
        tests++; if (o_ill !== 1'b1) begin fails++; $display("FAIL ill_csr9_flag got %b want 1", o_ill); end
        tests++; if (o_data !== 32'd0) begin fails++; $display("FAIL ill_csr9_data got %h want 0", o_data); end
        tests++; if (o_rd !== 5'd4) begin fails++; $display("FAIL ill_csr9_rd got %0d want 4", o_rd); end
        issue(3'b100, 12'd1, 5'd3, 32'h12345678, 5'd2);
        tests++; if (o_we_cnt !== 0) begin fails++; $display("FAIL ill_f3_100_we got %0d want 0", o_we_cnt); end
        tests++; if (o_ill !== 1'b1) begin fails++; $display("FAIL ill_f3_100_flag got %b want 1", o_ill); end
        tests++; if (o_data !== 32'd0) begin fails++; $display("FAIL ill_f3_100_data got %h want 0", o_data); end
        issue(3'b000, 12'd3, 5'd3, 32'h12345678, 5'd2);
        tests++; if (o_ill !== 1'b1) begin fails++; $display("FAIL ill_f3_000_flag got %b want 1", o_ill); end
        tests++; if (o_data !== 32'd0) begin fails++; $display("FAIL ill_f3_000_data got %h want 0", o_data); end
        issue(CSR_RS, 12'd8, 5'd3, 32'h1, 5'd2);
        tests++; if (o_ill !== 1'b1) begin fails++; $display("FAIL ill_csr8_flag got %b want 1", o_ill); end
        tests++; if (o_we_cnt !== 0) begin fails++; $display("FAIL ill_csr8_we got %0d want 0", o_we_cnt); end
        issue(CSR_RS, 12'd3, 5'd0, 32'd0, 5'd1);
        tests++; if (o_data !== 32'hDEADBEF0) begin fails++; $display("FAIL ill_no_side_effect got %h want deadbef0", o_data); end
    endtask

    task automatic test_backpressure();
        bus.resp_ready = 1'b0;
        issue(CSR_RS, 12'd3, 5'd0, 32'hFFFF, 5'd11);
        tests++; if (o_lat !== 3) begin fails++; $display("FAIL bp_latency got %0d want 3", o_lat); end
        tests++; if (o_data !== 32'hDEADBEF0) begin fails++; $display("FAIL bp_data got %h want deadbef0", o_data); end
        bus.req_funct3   = CSR_RW;
        bus.req_csr      = 12'd2;
        bus.req_src_idx  = 5'd1;
        bus.req_rs1_data = 32'h000000A5;
        bus.req_rd       = 5'd12;
        bus.req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++; if (bus.resp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.resp_valid); end
            tests++; if (bus.resp_data !== 32'hDEADBEF0) begin fails++; $display("FAIL bp_data[%0d] got %h want deadbef0", i, bus.resp_data); end
            tests++; if (bus.resp_rd !== 5'd11) begin fails++; $display("FAIL bp_rd[%0d] got %0d want 11", i, bus.resp_rd); end
            tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL bp_req_ready[%0d] got %b want 0", i, bus.req_ready); end
            tests++; if (csr_addr !== 32'd3) begin fails++; $display("FAIL bp_addr[%0d] got %h want 3", i, csr_addr); end
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", bus.req_ready); end
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got %b want 0", bus.resp_valid); end
        issue(CSR_RW, 12'd2, 5'd1, 32'h000000A5, 5'd12);
        tests++; if (o_wdata !== 32'h000000A5) begin fails++; $display("FAIL bp_second_wdata got %h want a5", o_wdata); end
        tests++; if (o_data !== 32'd0) begin fails++; $display("FAIL bp_second_data got %h want 0", o_data); end
        tests++; if (o_rd !== 5'd12) begin fails++; $display("FAIL bp_second_rd got %0d want 12", o_rd); end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        @(negedge clk);
        t0 = $time;
        issue(CSR_RW, 12'd5, 5'd1, 32'h11111111, 5'd3);
        issue(CSR_RW, 12'd5, 5'd1, 32'h22222222, 5'd3);
        t1 = $time;
        tests++; if (o_data !== 32'h11111111) begin fails++; $display("FAIL b2b_data got %h want 11111111", o_data); end
        tests++; if (o_lat !== 3) begin fails++; $display("FAIL b2b_latency got %0d want 3", o_lat); end
        tests++; if (t1 - t0 > 100) begin fails++; $display("FAIL b2b_duration got %0d want <=100", t1 - t0); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_funct3   = CSR_RW;
        bus.req_csr      = 12'd4;
        bus.req_src_idx  = 5'd1;
        bus.req_rs1_data = 32'h00001234;
        bus.req_rd       = 5'd7;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (csr_we !== 1'b1) begin fails++; $display("FAIL mid_we_before got %b want 1", csr_we); end
        #1 reset = 1'b1;
        #1;
        tests++; if (csr_we !== 1'b0) begin fails++; $display("FAIL mid_we_after got %b want 0", csr_we); end
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL mid_req_ready got %b want 1", bus.req_ready); end
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL mid_resp_valid got %b want 0", bus.resp_valid); end
        tests++; if (csr_addr !== 32'd0) begin fails++; $display("FAIL mid_addr got %h want 0", csr_addr); end
        tests++; if (csr_wdata !== 32'd0) begin fails++; $display("FAIL mid_wdata got %h want 0", csr_wdata); end
        @(negedge clk);
        reset = 1'b0;
        issue(CSR_RS, 12'd4, 5'd0, 32'd0, 5'd9);
        tests++; if (o_data !== 32'd0) begin fails++; $display("FAIL mid_dropped got %h want 0", o_data); end
        tests++; if (o_lat !== 3) begin fails++; $display("FAIL mid_latency got %0d want 3", o_lat); end
        issue(CSR_RW, 12'd4, 5'd1, 32'h00001234, 5'd7);
        tests++; if (o_we_cnt !== 1) begin fails++; $display("FAIL mid_redo_we got %0d want 1", o_we_cnt); end
        tests++; if (o_wdata !== 32'h00001234) begin fails++; $display("FAIL mid_redo_wdata got %h want 1234", o_wdata); end
        issue(CSR_RS, 12'd4, 5'd0, 32'd0, 5'd9);
        tests++; if (o_data !== 32'h00001234) begin fails++; $display("FAIL mid_readback got %h want 1234", o_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tests            = 0;
        fails            = 0;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_funct3   = '0;
        bus.req_csr      = '0;
        bus.req_src_idx  = '0;
        bus.req_rs1_data = '0;
        bus.req_rd       = '0;
        bus.resp_ready   = 1'b1;
        test_reset();
        test_rw();
        test_set_clear();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
